// File: rtl/instr_encoder.sv
// RV32I instruction encoder with a single-slot registered output and byte-address tagging.
// Optional immediate/op range checking is enabled by defining INSTR_ENC_RANGE_CHK_EN.
module instr_encoder #(
    parameter int unsigned             ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]       BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [12:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
`ifdef INSTR_ENC_RANGE_CHK_EN
    output logic              out_err,
`endif
    output logic [ADDR_W-1:0] out_addr
);

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SLLI = 3'd1,
        OP_ADDI = 3'd2,
        OP_LW   = 3'd3,
        OP_SW   = 3'd4,
        OP_BEQ  = 3'd5,
        OP_BNE  = 3'd6,
        OP_RSVD = 3'd7
    } op_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    op_t               op;
    logic [31:0]       enc;
    logic [31:0]       word;
    logic              accept;
    logic [ADDR_W-1:0] next_addr;

    assign op = op_t'(in_op);

    always_comb begin
        enc = NOP;
        case (op)
            OP_ADD:  enc = {7'b0000000, in_rs2, in_rs1, 3'b000, in_rd, 7'b0110011};
            OP_SLLI: enc = {7'b0000000, in_imm[4:0], in_rs1, 3'b001, in_rd, 7'b0010011};
            OP_ADDI: enc = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'b0010011};
            OP_LW:   enc = {in_imm[11:0], in_rs1, 3'b010, in_rd, 7'b0000011};
            OP_SW:   enc = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011};
            OP_BEQ:  enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b000,
                            in_imm[4:1], in_imm[11], 7'b1100011};
            OP_BNE:  enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, 3'b001,
                            in_imm[4:1], in_imm[11], 7'b1100011};
            default: enc = NOP;
        endcase
    end

`ifdef INSTR_ENC_RANGE_CHK_EN
    logic illegal;

    // 12-bit fields are legal when the 13-bit immediate sign-extends from bit 11.
    always_comb begin
        illegal = 1'b0;
        case (op)
            OP_SLLI:              illegal = |in_imm[12:5];
            OP_ADDI, OP_LW, OP_SW: illegal = (in_imm[12] != in_imm[11]);
            OP_BEQ, OP_BNE:       illegal = in_imm[0];
            OP_RSVD:              illegal = 1'b1;
            default:              illegal = 1'b0;
        endcase
    end

    assign word = illegal ? NOP : enc;
`else
    assign word = enc;
`endif

    // A reset that lands mid-stall still advertises readiness; rst takes priority over accept.
    assign in_ready = rst || !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_addr  <= '0;
            next_addr <= BASE_ADDR;
`ifdef INSTR_ENC_RANGE_CHK_EN
            out_err   <= 1'b0;
`endif
        end else if (accept) begin
            out_valid <= 1'b1;
            out_instr <= word;
            out_addr  <= next_addr;
            next_addr <= next_addr + ADDR_W'(4);
`ifdef INSTR_ENC_RANGE_CHK_EN
            out_err   <= illegal;
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder: encodings, handshake, stall, reset-in-stall, address wrap.
// Checks out_err only when INSTR_ENC_RANGE_CHK_EN is defined.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        rst_b;
    logic [2:0]  in_op;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [12:0] in_imm;

    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [31:0] b_out_instr;
    logic [9:0]  b_out_addr;
`ifdef INSTR_ENC_RANGE_CHK_EN
    logic        out_err;
    logic        b_out_err;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_encoder dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_op    (in_op),
        .in_rd    (in_rd),
        .in_rs1   (in_rs1),
        .in_rs2   (in_rs2),
        .in_imm   (in_imm),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instr(out_instr),
`ifdef INSTR_ENC_RANGE_CHK_EN
        .out_err  (out_err),
`endif
        .out_addr (out_addr)
    );

    instr_encoder #(.ADDR_W(10), .BASE_ADDR(10'h100)) dut_b (
        .clk      (clk),
        .rst      (rst_b),
        .in_valid (b_in_valid),
        .in_ready (b_in_ready),
        .in_op    (in_op),
        .in_rd    (in_rd),
        .in_rs1   (in_rs1),
        .in_rs2   (in_rs2),
        .in_imm   (in_imm),
        .out_valid(b_out_valid),
        .out_ready(b_out_ready),
        .out_instr(b_out_instr),
`ifdef INSTR_ENC_RANGE_CHK_EN
        .out_err  (b_out_err),
`endif
        .out_addr (b_out_addr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int op, input int rd, input int rs1, input int rs2, input int imm);
        logic [31:0] v;
        v      = imm;
        in_op  = op[2:0];
        in_rd  = rd[4:0];
        in_rs1 = rs1[4:0];
        in_rs2 = rs2[4:0];
        in_imm = v[12:0];
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_word(input string tag, input logic [31:0] instr, input logic [31:0] addr,
                              input logic err);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_instr"}, out_instr, instr);
        check({tag, "_addr"}, out_addr, addr);
`ifdef INSTR_ENC_RANGE_CHK_EN
        check({tag, "_err"}, {31'd0, out_err}, {31'd0, err});
`else
        if (err) $display("note: %s error flag not present in this build", tag);
`endif
    endtask

    initial begin
        rst = 1'b1; rst_b = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1;
        b_in_valid = 1'b0; b_out_ready = 1'b1;
        drive(0, 0, 0, 0, 0);
        tick(); tick();
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        check("rst_instr", out_instr, 32'd0);
        check("rst_addr", out_addr, 32'd0);
        rst = 1'b0;

        // First word after reset; rs2 is ignored by ADDI.
        drive(2, 22, 22, 5, 1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check_word("addi", 32'h001B0B13, 32'd0, 1'b0);
        tick();
        check("drain_drop", {31'd0, out_valid}, 32'd0);

        rst = 1'b1; tick(); rst = 1'b0;

        // Back-to-back stream with out_ready held high.
        in_valid = 1'b1;
        drive(1, 10, 22, 0, 2);    tick(); check_word("slli", 32'h002B1513, 32'd0, 1'b0);
        drive(0, 10, 10, 25, 0);   tick(); check_word("add",  32'h01950533, 32'd4, 1'b0);
        drive(3, 9, 10, 0, 0);     tick(); check_word("lw",   32'h00052483, 32'd8, 1'b0);
        drive(6, 31, 9, 24, 12);   tick(); check_word("bne",  32'h01849663, 32'd12, 1'b0);
        drive(5, 0, 0, 0, -20);    tick(); check_word("beq",  32'hFE0006E3, 32'd16, 1'b0);
        drive(4, 7, 2, 5, -4);     tick(); check_word("sw",   32'hFE512E23, 32'd20, 1'b0);
        in_valid = 1'b0;
        tick();
        check("stream_drop", {31'd0, out_valid}, 32'd0);

        // Backpressure: first word loads, second waits three cycles.
        out_ready = 1'b0;
        drive(2, 1, 0, 0, 5);
        in_valid = 1'b1;
        tick();
        drive(2, 2, 0, 0, 6);
        for (int i = 0; i < 3; i++) begin
            check("stall_ready", {31'd0, in_ready}, 32'd0);
            check_word("stall_hold", 32'h00500093, 32'd24, 1'b0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("release_ready", {31'd0, in_ready}, 32'd1);
        tick();
        check_word("release", 32'h00600113, 32'd28, 1'b0);

        // Reserved op and range boundaries.
        drive(7, 3, 4, 5, 0);      tick(); check_word("op7", 32'h00000013, 32'd32, 1'b1);
`ifdef INSTR_ENC_RANGE_CHK_EN
        drive(2, 0, 0, 0, 2048);   tick(); check_word("addi_2048", 32'h00000013, 32'd36, 1'b1);
        drive(2, 0, 0, 0, -2048);  tick(); check_word("addi_m2048", 32'h80000013, 32'd40, 1'b0);
        drive(5, 0, 0, 0, 7);      tick(); check_word("beq_odd", 32'h00000013, 32'd44, 1'b1);
        drive(1, 0, 0, 0, 32);     tick(); check_word("slli_32", 32'h00000013, 32'd48, 1'b1);
`else
        drive(2, 0, 0, 0, 2048);   tick(); check_word("addi_2048", 32'h80000013, 32'd36, 1'b0);
        drive(2, 0, 0, 0, -2048);  tick(); check_word("addi_m2048", 32'h80000013, 32'd40, 1'b0);
        drive(5, 0, 0, 0, 7);      tick(); check_word("beq_odd", 32'h00000363, 32'd44, 1'b0);
        drive(1, 0, 0, 0, 32);     tick(); check_word("slli_32", 32'h00001013, 32'd48, 1'b0);
`endif
        in_valid = 1'b0;
        tick();

        // Second instance: reset during a stall, then wrap of a 10-bit counter from 0x100.
        rst_b = 1'b0;
        b_out_ready = 1'b0;
        drive(0, 1, 2, 3, 0);
        b_in_valid = 1'b1;
        tick();
        check("b_first_addr", {22'd0, b_out_addr}, 32'h100);
        tick();
        check("b_stall_ready", {31'd0, b_in_ready}, 32'd0);
        rst_b = 1'b1;
        #1;
        check("b_rst_ready", {31'd0, b_in_ready}, 32'd1);
        tick();
        check("b_rst_valid", {31'd0, b_out_valid}, 32'd0);
        check("b_rst_instr", b_out_instr, 32'd0);
        rst_b = 1'b0;
        b_out_ready = 1'b1;
        tick();
        check("b_after_rst_valid", {31'd0, b_out_valid}, 32'd1);
        check("b_after_rst_addr", {22'd0, b_out_addr}, 32'h100);
        check("b_after_rst_instr", b_out_instr, 32'h003100B3);
        for (int i = 0; i < 191; i++) tick();
        check("b_wrap_last", {22'd0, b_out_addr}, 32'h3FC);
        tick();
        check("b_wrap_zero", {22'd0, b_out_addr}, 32'h000);
        b_in_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Pipelined RV32I instruction encoder. It is the inverse of the datapath's immediate generator: it takes an operation code, register indices and a signed immediate, and packs them into a 32-bit instruction word with the correct immediate scattering. It sits in front of instruction memory as the program loader/test-program builder. Each emitted word is tagged with a sequential byte address.

## Interface
Parameters:
- `ADDR_W`, default 32: width of `out_addr`.
- `BASE_ADDR`, default 0: first address emitted after reset.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `in_valid` in 1: input fields valid.
- `in_ready` out 1: encoder can accept this cycle.
- `in_op` in 3: 0 ADD, 1 SLLI, 2 ADDI, 3 LW, 4 SW, 5 BEQ, 6 BNE, 7 reserved.
- `in_rd` in 5: destination register.
- `in_rs1` in 5: source register 1.
- `in_rs2` in 5: source register 2.
- `in_imm` in 13: signed immediate; byte offset for branches.
- `out_valid` out 1: `out_instr`/`out_addr` valid.
- `out_ready` in 1: consumer accepts this cycle.
- `out_instr` out 32: encoded instruction.
- `out_addr` out `ADDR_W`: byte address of `out_instr`.
- `out_err` out 1: immediate or op illegal (only with `INSTR_ENC_RANGE_CHK_EN`).

## Operation
Encodings, written as funct7 | rs2 | rs1 | funct3 | rd | opcode:
- ADD: 0000000 | rs2 | rs1 | 000 | rd | 0110011.
- SLLI: 0000000 | imm[4:0] | rs1 | 001 | rd | 0010011.
- ADDI: imm[11:0] | rs1 | 000 | rd | 0010011.
- LW: imm[11:0] | rs1 | 010 | rd | 0000011.
- SW: imm[11:5] | rs2 | rs1 | 010 | imm[4:0] | 0100011.
- BEQ/BNE: imm[12], imm[10:5] | rs2 | rs1 | 000/001 | imm[4:1], imm[11] | 1100011.

Fields not used by an op are ignored. For example, `in_rd` is ignored for SW and branches, and `in_rs2` is ignored for I-types.

Op 7 encodes as NOP (0x00000013).

Output stage is a single register slot (`out_valid`, `out_instr`, `out_addr`, `out_err`):
- `in_ready = !out_valid || out_ready`.
- Input is accepted when `in_valid && in_ready`, and the slot loads on the next edge.

Address counter:
- Holds the address of the next word to be loaded.
- Reset value is `BASE_ADDR`.
- Advances by 4 on every accept.
- Wraps modulo 2^`ADDR_W`.

## Timing
- Latency is 1 cycle: an accept in cycle N makes `out_valid`=1 in cycle N+1.
- Throughput is 1 word/cycle while `out_ready`=1.
- Simultaneous drain and accept (`out_valid && out_ready && in_valid`): the slot reloads with the new word with no bubble, and `out_valid` stays 1.
- Stall (`out_valid && !out_ready`):
  - `out_instr`, `out_addr` and `out_err` are held stable.
  - `in_ready`=0.
  - The counter does not advance.
- `out_valid` drops the cycle after a drain with no accept.
- Reset values, applied while `rst`=1 regardless of handshake state:
  - `out_valid`=0, `out_instr`=0, `out_addr`=0, `out_err`=0, counter=`BASE_ADDR`.
  - `in_ready` reads 1 during reset.
- Reset mid-stall discards the held word.
- The first accept after reset yields `out_addr`=`BASE_ADDR`.

## Configuration
`INSTR_ENC_RANGE_CHK_EN`, when defined:
- `out_err` exists.
- An instruction is illegal if any of the following hold:
  - ADDI, LW or SW imm is outside -2048..2047.
  - SLLI imm is outside 0..31.
  - A branch imm is odd.
  - op is 7.
- An illegal instruction emits NOP 0x00000013 with `out_err`=1.
- The counter still advances by 4.

When undefined:
- The `out_err` port is absent.
- Immediates are truncated to the field bits without checking.
- Op 7 still emits NOP.

## Test plan
- Reset, then ADDI rd=22 rs1=22 imm=1 -> next cycle `out_instr`=0x001B0B13, `out_addr`=0, `out_err`=0.
- Back-to-back accepts with `out_ready`=1 held, all with `out_err`=0:
  - SLLI rd=10 rs1=22 imm=2 -> 0x002B1513 @0.
  - ADD rd=10 rs1=10 rs2=25 -> 0x01950533 @4.
  - LW rd=9 rs1=10 imm=0 -> 0x00052483 @8.
- Branches: BNE rs1=9 rs2=24 imm=12 -> 0x01849663; BEQ rs1=0 rs2=0 imm=-20 -> 0xFE0006E3; SW rs1=2 rs2=5 imm=-4 -> 0xFE512E23.
- Backpressure: `out_ready`=0 for 3 cycles with `in_valid`=1 -> `in_ready`=0, outputs stable, no counter advance; release -> queued word at next address, no loss or duplication.
- `INSTR_ENC_RANGE_CHK_EN` illegal cases: ADDI imm=2048 -> 0x00000013, `out_err`=1, address +4; BEQ imm=7 -> `out_err`=1; op 7 -> `out_err`=1.
- Assert `rst` during a stall with `BASE_ADDR`=0x100 -> `out_valid`=0 next cycle; first accept after release emits `out_addr`=0x100.
